// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register numbers, exception-type codes,
// reset/entry constants, field positions and write masks.
package cp0_regs_pkg;

   typedef enum logic [4:0] {
      REG_BADVADDR = 5'd8,
      REG_COUNT    = 5'd9,
      REG_COMPARE  = 5'd11,
      REG_STATUS   = 5'd12,
      REG_CAUSE    = 5'd13,
      REG_EPC      = 5'd14
   } cp0_reg_e;

   localparam logic [31:0] EXC_NONE = 32'h00;
   localparam logic [31:0] EXC_INT  = 32'h01;
   localparam logic [31:0] EXC_ADEL = 32'h04;
   localparam logic [31:0] EXC_ADES = 32'h05;
   localparam logic [31:0] EXC_SYS  = 32'h08;
   localparam logic [31:0] EXC_BP   = 32'h09;
   localparam logic [31:0] EXC_RI   = 32'h0a;
   localparam logic [31:0] EXC_OV   = 32'h0c;
   localparam logic [31:0] EXC_ERET = 32'h0e;

   localparam logic [31:0] EXC_ENTRY_DEF  = 32'hBFC00380;
   localparam logic [31:0] STATUS_RST_DEF = 32'h0040FF00;

   // Status field positions
   localparam int unsigned ST_IE  = 0;
   localparam int unsigned ST_EXL = 1;
   localparam int unsigned ST_BEV = 22;

   // Cause field positions
   localparam int unsigned CA_EXC_LO = 2;
   localparam int unsigned CA_EXC_HI = 6;
   localparam int unsigned CA_IP_LO  = 8;
   localparam int unsigned CA_IP_HI  = 15;
   localparam int unsigned CA_BD     = 31;

   // Bits an mtc0 may change: Status IM/EXL/IE, Cause IP[1:0]
   localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;

   // ExcCode recorded for an exception type: Int records 0, others record themselves
   function automatic logic [4:0] exc_code(input logic [31:0] t);
      return (t == EXC_INT) ? 5'd0 : t[4:0];
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair and the sticky Count==Compare interrupt flag.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   // Free-running counter; an mtc0 to Count replaces that cycle's increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           count <= '0;
      else if (count_we) count <= wdata;
      else               count <= count + 32'd1;
   end

   // Compare register, written only by mtc0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             compare <= '0;
      else if (compare_we) compare <= wdata;
   end

   // Sticky match flag; a Compare write clears it even on a same-cycle match
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      timer_int <= 1'b0;
      else if (compare_we)                          timer_int <= 1'b0;
      else if (compare != '0 && count == compare)   timer_int <= 1'b1;
   end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: Status/Cause/EPC/BadVAddr plus the Count/Compare timer,
// mtc0/mfc0 access, exception entry/return and pipeline redirect.
module cp0_regs
   import cp0_regs_pkg::*;
#(
   parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEF,
   parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o,
   input  logic [5:0]  int_i,
   input  logic [31:0] exc_type_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        timer_int_o
);

   logic        exc_any, is_eret, exc_take, mtc0;
   logic [31:0] count, compare, status, cause, epc, badvaddr;

   assign exc_any  = (exc_type_i != EXC_NONE);
   assign is_eret  = (exc_type_i == EXC_ERET);
   assign exc_take = exc_any && !is_eret;
   // any exception (eret included) drops a coincident mtc0
   assign mtc0     = we_i && !exc_any;

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0 && (waddr_i == REG_COUNT)),
      .compare_we (mtc0 && (waddr_i == REG_COMPARE)),
      .wdata      (wdata_i),
      .count      (count),
      .compare    (compare),
      .timer_int  (timer_int_o)
   );

   // Status: EXL set on entry, cleared on eret, masked fields writable by mtc0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         status <= STATUS_RST;
      else if (exc_take)
         status[ST_EXL] <= 1'b1;
      else if (is_eret)
         status[ST_EXL] <= 1'b0;
      else if (mtc0 && (waddr_i == REG_STATUS))
         status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
   end

   // Cause: IP[7:2] sampled every cycle, ExcCode/BD on entry, IP[1:0] by mtc0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause <= '0;
      end else begin
         cause[CA_IP_HI:CA_IP_LO+2] <= {int_i[5] | timer_int_o, int_i[4:0]};
         if (exc_take) begin
            cause[CA_EXC_HI:CA_EXC_LO] <= exc_code(exc_type_i);
            if (!status[ST_EXL]) cause[CA_BD] <= in_delayslot_i;
         end else if (mtc0 && (waddr_i == REG_CAUSE)) begin
            cause <= (cause & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
            cause[CA_IP_HI:CA_IP_LO+2] <= {int_i[5] | timer_int_o, int_i[4:0]};
         end
      end
   end

   // EPC: captured on a non-nested entry, otherwise writable by mtc0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         epc <= '0;
      else if (exc_take) begin
         if (!status[ST_EXL]) epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
      end else if (mtc0 && (waddr_i == REG_EPC))
         epc <= wdata_i;
   end

   // BadVAddr: loaded only by address-error exceptions
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         badvaddr <= '0;
      else if (exc_take && (exc_type_i == EXC_ADEL || exc_type_i == EXC_ADES))
         badvaddr <= bad_addr_i;
   end

   // mfc0 read mux; unimplemented numbers read zero
   always_comb begin
      rdata_o = '0;
      case (raddr_i)
         REG_BADVADDR: rdata_o = badvaddr;
         REG_COUNT:    rdata_o = count;
         REG_COMPARE:  rdata_o = compare;
         REG_STATUS:   rdata_o = status;
         REG_CAUSE:    rdata_o = cause;
         REG_EPC:      rdata_o = epc;
         default:      rdata_o = '0;
      endcase
   end

   // Flush and redirect, held quiet during reset
   always_comb begin
      flush_o  = 1'b0;
      new_pc_o = '0;
      if (!rst && exc_any) begin
         flush_o  = 1'b1;
         new_pc_o = is_eret ? epc : EXC_ENTRY;
      end
   end

   assign status_o = status;
   assign cause_o  = cause;
   assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: vector table for exception/mtc0 traffic,
// hand-written sequences for timer, counter wrap and asynchronous reset.
module tb_cp0_regs;

   logic        clk, rst, we_i, in_delayslot_i, flush_o, timer_int_o;
   logic [4:0]  waddr_i, raddr_i;
   logic [5:0]  int_i;
   logic [31:0] wdata_i, rdata_o, exc_type_i, pc_i, bad_addr_i;
   logic [31:0] status_o, cause_o, epc_o, new_pc_o;

   cp0_regs #(.EXC_ENTRY(32'hBFC00380), .STATUS_RST(32'h0040FF00)) dut (
      .clk            (clk),
      .rst            (rst),
      .we_i           (we_i),
      .waddr_i        (waddr_i),
      .wdata_i        (wdata_i),
      .raddr_i        (raddr_i),
      .rdata_o        (rdata_o),
      .int_i          (int_i),
      .exc_type_i     (exc_type_i),
      .pc_i           (pc_i),
      .in_delayslot_i (in_delayslot_i),
      .bad_addr_i     (bad_addr_i),
      .status_o       (status_o),
      .cause_o        (cause_o),
      .epc_o          (epc_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o),
      .timer_int_o    (timer_int_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q [$];
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] exc;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bad;
      logic [4:0]  raddr;
      logic        e_flush;
      logic [31:0] e_newpc;
      logic [31:0] e_status;
      logic [31:0] e_cause;
      logic [31:0] e_epc;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs [16];

   task automatic expect_v(input string n, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic check_v(input logic [31:0] act);
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_underflow: got %h with no expectation queued", act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e.val) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we_i = 1'b1; waddr_i = a; wdata_i = d;
      @(posedge clk);
      #1;
      we_i = 1'b0;
   endtask

   task automatic rd_check(input logic [4:0] a, input logic [31:0] v, input string n);
      raddr_i = a;
      #1;
      expect_v(n, v);
      check_v(rdata_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //         we   waddr  wdata          exc     pc             ds    bad            raddr  flush  newpc          status         cause          epc            rdata
      vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'h08, 32'h80000010, 1'b1, 32'h0,        5'd8,  1'b1, 32'hBFC00380, 32'h0040FF02, 32'h80000020, 32'h8000000C, 32'h0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        32'h0e, 32'h0,        1'b0, 32'h0,        5'd8,  1'b1, 32'h8000000C, 32'h0040FF00, 32'h80000020, 32'h8000000C, 32'h0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        32'h04, 32'h80000100, 1'b0, 32'h80000003, 5'd8,  1'b1, 32'hBFC00380, 32'h0040FF02, 32'h00000010, 32'h80000100, 32'h80000003};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        32'h0c, 32'h00001000, 1'b1, 32'h0,        5'd8,  1'b1, 32'hBFC00380, 32'h0040FF02, 32'h00000030, 32'h80000100, 32'h80000003};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        32'h0e, 32'h0,        1'b0, 32'h0,        5'd14, 1'b1, 32'h80000100, 32'h0040FF00, 32'h00000030, 32'h80000100, 32'h80000100};
      vecs[5]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 32'h0a, 32'h00002000, 1'b0, 32'h0,        5'd12, 1'b1, 32'hBFC00380, 32'h0040FF02, 32'h00000028, 32'h00002000, 32'h0040FF02};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        32'h0e, 32'h0,        1'b0, 32'h0,        5'd13, 1'b1, 32'h00002000, 32'h0040FF00, 32'h00000028, 32'h00002000, 32'h00000028};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        32'h01, 32'h00003000, 1'b0, 32'h0,        5'd13, 1'b1, 32'hBFC00380, 32'h0040FF02, 32'h00000000, 32'h00003000, 32'h00000000};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        32'h05, 32'h00004000, 1'b0, 32'h00001234, 5'd8,  1'b1, 32'hBFC00380, 32'h0040FF02, 32'h00000014, 32'h00003000, 32'h00001234};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        32'h0e, 32'h0,        1'b0, 32'h0,        5'd12, 1'b1, 32'h00003000, 32'h0040FF00, 32'h00000014, 32'h00003000, 32'h0040FF00};
      vecs[10] = '{1'b1, 5'd12, 32'h0000A501, 32'h00, 32'h0,        1'b0, 32'h0,        5'd12, 1'b0, 32'h0,        32'h0040A501, 32'h00000014, 32'h00003000, 32'h0040A501};
      vecs[11] = '{1'b1, 5'd13, 32'hFFFFFFFF, 32'h00, 32'h0,        1'b0, 32'h0,        5'd13, 1'b0, 32'h0,        32'h0040A501, 32'h00000314, 32'h00003000, 32'h00000314};
      vecs[12] = '{1'b1, 5'd14, 32'hDEADBEEF, 32'h00, 32'h0,        1'b0, 32'h0,        5'd14, 1'b0, 32'h0,        32'h0040A501, 32'h00000314, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[13] = '{1'b1, 5'd8,  32'h00000000, 32'h00, 32'h0,        1'b0, 32'h0,        5'd8,  1'b0, 32'h0,        32'h0040A501, 32'h00000314, 32'hDEADBEEF, 32'h00001234};
      vecs[14] = '{1'b1, 5'd3,  32'h00000001, 32'h00, 32'h0,        1'b0, 32'h0,        5'd3,  1'b0, 32'h0,        32'h0040A501, 32'h00000314, 32'hDEADBEEF, 32'h00000000};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        32'h0e, 32'h0,        1'b0, 32'h0,        5'd14, 1'b1, 32'hDEADBEEF, 32'h0040A501, 32'h00000314, 32'hDEADBEEF, 32'hDEADBEEF};

      rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd9;
      int_i = '0; exc_type_i = 32'h08; pc_i = '0; in_delayslot_i = 1'b0; bad_addr_i = '0;

      // reset state, with an exception code present to show flush is held off
      #2;
      expect_v("rst_count", 32'h0);            check_v(rdata_o);
      expect_v("rst_status", 32'h0040FF00);    check_v(status_o);
      expect_v("rst_cause", 32'h0);            check_v(cause_o);
      expect_v("rst_epc", 32'h0);              check_v(epc_o);
      expect_v("rst_timer", 32'h0);            check_v(32'(timer_int_o));
      expect_v("rst_flush", 32'h0);            check_v(32'(flush_o));
      expect_v("rst_newpc", 32'h0);            check_v(new_pc_o);
      rd_check(5'd12, 32'h0040FF00, "rst_rd_status");
      @(negedge clk);
      rst = 1'b0; exc_type_i = '0;

      // timer: Compare=5 written while Count=0
      wr(5'd9, 32'h0);
      wr(5'd11, 32'h5);
      rd_check(5'd9, 32'h1, "count_after_cmp_wr");
      repeat (3) step();
      step();
      expect_v("timer_before_match", 32'h0);   check_v(32'(timer_int_o));
      rd_check(5'd9, 32'h5, "count_at_match");
      step();
      expect_v("timer_set", 32'h1);            check_v(32'(timer_int_o));
      expect_v("cause_ip7_lag", 32'h0);        check_v(32'(cause_o[15]));
      step();
      expect_v("cause_ip7_set", 32'h1);        check_v(32'(cause_o[15]));
      repeat (3) step();
      expect_v("timer_sticky", 32'h1);         check_v(32'(timer_int_o));
      wr(5'd11, 32'h100);
      expect_v("timer_clr_by_cmp", 32'h0);     check_v(32'(timer_int_o));
      step();
      expect_v("cause_ip7_clr", 32'h0);        check_v(32'(cause_o[15]));

      // Compare write during a match: clear wins
      wr(5'd9, 32'hFF);
      step();
      rd_check(5'd9, 32'h100, "count_eq_cmp");
      wr(5'd11, 32'h200);
      expect_v("clear_wins_match", 32'h0);     check_v(32'(timer_int_o));
      step();
      expect_v("clear_wins_after", 32'h0);     check_v(32'(timer_int_o));

      // Count wrap
      wr(5'd9, 32'hFFFFFFFF);
      rd_check(5'd9, 32'hFFFFFFFF, "count_max");
      step();
      expect_v("count_wrap", 32'h0);           check_v(rdata_o);

      // asynchronous reset mid-run at Count=0x55 with timer pending
      wr(5'd11, 32'h53);
      wr(5'd9, 32'h50);
      wr(5'd12, 32'h3);
      expect_v("status_wr_mask", 32'h00400003); check_v(status_o);
      repeat (4) step();
      rd_check(5'd9, 32'h55, "count_pre_rst");
      expect_v("timer_pre_rst", 32'h1);        check_v(32'(timer_int_o));
      rst = 1'b1;
      #1;
      expect_v("midrst_count", 32'h0);         check_v(rdata_o);
      expect_v("midrst_status", 32'h0040FF00); check_v(status_o);
      expect_v("midrst_timer", 32'h0);         check_v(32'(timer_int_o));
      expect_v("midrst_cause", 32'h0);         check_v(cause_o);
      @(negedge clk);
      rst = 1'b0;

      // exception / eret / mtc0 vector table
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
         exc_type_i = vecs[i].exc; pc_i = vecs[i].pc; in_delayslot_i = vecs[i].ds;
         bad_addr_i = vecs[i].bad; raddr_i = vecs[i].raddr;
         expect_v($sformatf("v%0d_flush", i), 32'(vecs[i].e_flush));
         expect_v($sformatf("v%0d_newpc", i), vecs[i].e_newpc);
         #1;
         check_v(32'(flush_o));
         check_v(new_pc_o);
         expect_v($sformatf("v%0d_status", i), vecs[i].e_status);
         expect_v($sformatf("v%0d_cause", i), vecs[i].e_cause);
         expect_v($sformatf("v%0d_epc", i), vecs[i].e_epc);
         expect_v($sformatf("v%0d_rdata", i), vecs[i].e_rd);
         step();
         check_v(status_o);
         check_v(cause_o);
         check_v(epc_o);
         check_v(rdata_o);
      end

      // hardware interrupt lines into Cause.IP[7:2]
      @(negedge clk);
      we_i = 1'b0; exc_type_i = '0; in_delayslot_i = 1'b0; int_i = 6'b101010;
      step();
      expect_v("cause_int_lines", 32'h0000AB14); check_v(cause_o);
      @(negedge clk);
      int_i = '0;
      step();
      expect_v("cause_int_clear", 32'h00000314); check_v(cause_o);

      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_leftover: got %0d pending expectations expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
